// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined floating-point multiplier with valid/ready handshake
//
// Purpose: multiplies two packed {sgn, exp, mant} operands. Denormals are treated
// as zero and results that would be denormal flush to +0. Rounding is truncate or
// round-to-nearest-even, chosen per item.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     operand handshake
//   op_a_i, op_b_i, rnd_rne_i   operands and rounding mode (1 = RNE)
//   out_valid_o / out_ready_i   result handshake
//   result_o, flags_o           product and {invalid, overflow, underflow}
module fp_mul_pipe #(
    parameter int ExpW  = 8,
    parameter int MantW = 7,
    localparam int W    = 1 + ExpW + MantW
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    input  logic         rnd_rne_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] result_o,
    output logic [2:0]   flags_o
);

    localparam int PW   = 2 * MantW + 2;
    localparam int EW2  = ExpW + 2;
    localparam int BIAS = (1 << (ExpW - 1)) - 1;
    localparam int EMAX = (1 << ExpW) - 1;

    // Ready chain: a stage can load when it is empty or its content moves on.
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_rdy, s2_rdy, s3_rdy;

    assign s3_rdy     = !s3_valid_q || out_ready_i;
    assign s2_rdy     = !s2_valid_q || s3_rdy;
    assign s1_rdy     = !s1_valid_q || s2_rdy;
    assign in_ready_o = s1_rdy;

    // ---------------- S1: classify and multiply ----------------
    logic [ExpW-1:0]  exp_a, exp_b;
    logic [MantW-1:0] mant_a, mant_b;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic             s1_inv_d, s1_zero_d, s1_inf_d, s1_sgn_d;
    logic [PW-1:0]    s1_prod_d;
    logic [EW2-1:0]   s1_exp_d;

    assign exp_a  = op_a_i[W-2 -: ExpW];
    assign exp_b  = op_b_i[W-2 -: ExpW];
    assign mant_a = op_a_i[MantW-1:0];
    assign mant_b = op_b_i[MantW-1:0];
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (&exp_a) && (mant_a == '0);
    assign inf_b  = (&exp_b) && (mant_b == '0);
    assign nan_a  = (&exp_a) && (mant_a != '0);
    assign nan_b  = (&exp_b) && (mant_b != '0);

    assign s1_inv_d  = nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b);
    assign s1_zero_d = zero_a || zero_b;
    assign s1_inf_d  = inf_a || inf_b;
    assign s1_sgn_d  = op_a_i[W-1] ^ op_b_i[W-1];
    assign s1_prod_d = PW'({1'b1, mant_a}) * PW'({1'b1, mant_b});
    assign s1_exp_d  = EW2'(exp_a) + EW2'(exp_b);

    logic           s1_inv_q, s1_zero_q, s1_inf_q, s1_sgn_q, s1_rne_q;
    logic [PW-1:0]  s1_prod_q;
    logic [EW2-1:0] s1_exp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_rne_q   <= 1'b0;
            s1_prod_q  <= '0;
            s1_exp_q   <= '0;
        end else if (s1_rdy) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_inv_q  <= s1_inv_d;
                s1_zero_q <= s1_zero_d;
                s1_inf_q  <= s1_inf_d;
                s1_sgn_q  <= s1_sgn_d;
                s1_rne_q  <= rnd_rne_i;
                s1_prod_q <= s1_prod_d;
                s1_exp_q  <= s1_exp_d;
            end
        end
    end

    // ---------------- S2: normalise and round ----------------
    logic             norm;
    logic [PW-2:0]    nprod;     // product with the leading 1 dropped
    logic [MantW-1:0] mant_t;
    logic             guard, sticky, inc, carry;
    logic [MantW-1:0] s2_mant_d;
    logic [EW2-1:0]   s2_exp_d;

    assign norm   = s1_prod_q[PW-1];
    assign nprod  = norm ? s1_prod_q[PW-2:0] : {s1_prod_q[PW-3:0], 1'b0};
    assign mant_t = nprod[PW-2 -: MantW];
    assign guard  = nprod[PW-2-MantW];
    assign sticky = |nprod[PW-3-MantW:0];
    assign inc    = s1_rne_q && guard && (sticky || mant_t[0]);
    assign {carry, s2_mant_d} = {1'b0, mant_t} + (MantW + 1)'(inc);
    // Wraps modulo 2^EW2, which is exactly the two's complement signed result.
    assign s2_exp_d = s1_exp_q + EW2'(norm) + EW2'(carry) - EW2'(BIAS);

    logic             s2_inv_q, s2_zero_q, s2_inf_q, s2_sgn_q;
    logic [MantW-1:0] s2_mant_q;
    logic [EW2-1:0]   s2_exp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_sgn_q   <= 1'b0;
            s2_mant_q  <= '0;
            s2_exp_q   <= '0;
        end else if (s2_rdy) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_inv_q  <= s1_inv_q;
                s2_zero_q <= s1_zero_q;
                s2_inf_q  <= s1_inf_q;
                s2_sgn_q  <= s1_sgn_q;
                s2_mant_q <= s2_mant_d;
                s2_exp_q  <= s2_exp_d;
            end
        end
    end

    // ---------------- S3: special cases and output register ----------------
    logic [W-1:0] res_d;
    logic [2:0]   flags_d;

    always_comb begin
        res_d   = '0;
        flags_d = 3'b000;
        if (s2_inv_q) begin
            res_d   = {1'b0, {ExpW{1'b1}}, 1'b1, {(MantW - 1){1'b0}}};
            flags_d = 3'b100;
        end else if (s2_zero_q) begin
            res_d   = '0;
        end else if (s2_inf_q) begin
            res_d   = {s2_sgn_q, {ExpW{1'b1}}, {MantW{1'b0}}};
        end else if ($signed(s2_exp_q) <= $signed(EW2'(0))) begin
            res_d   = '0;
            flags_d = 3'b001;
        end else if ($signed(s2_exp_q) >= $signed(EW2'(EMAX))) begin
            res_d   = {s2_sgn_q, {ExpW{1'b1}}, {MantW{1'b0}}};
            flags_d = 3'b010;
        end else begin
            res_d   = {s2_sgn_q, s2_exp_q[ExpW-1:0], s2_mant_q};
        end
    end

    logic [W-1:0] res_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s3_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= 3'b000;
        end else if (s3_rdy) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid_o = s3_valid_q;
    assign result_o    = res_q;
    assign flags_o     = flags_q;

endmodule
